// File: rtl/rf_wb_sched.sv
// Write-back port scheduler: arbitrates the single register-file write port between the WB stage
// and a long-latency result FIFO, and keeps a busy scoreboard. Optional forwarding: RF_WB_FORWARD_EN.
module rf_wb_sched #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_wb_en,
    input  logic [4:0]  pipe_wb_rd,
    input  logic [31:0] pipe_wb_data,
    input  logic        lu_valid,
    input  logic [4:0]  lu_rd,
    input  logic [31:0] lu_data,
    output logic        lu_ready,
    input  logic        lu_issue,
    input  logic [4:0]  lu_issue_rd,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
`ifdef RF_WB_FORWARD_EN
    input  logic [31:0] rf_rs1_data,
    input  logic [31:0] rf_rs2_data,
    output logic [31:0] fwd_rs1_data,
    output logic [31:0] fwd_rs2_data,
`endif
    output logic        hazard_stall,
    output logic        pipe_hold,
    output logic        wb_en,
    output logic [4:0]  W_rd_index,
    output logic [31:0] wb_data
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned WW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] FullCnt = CW'(DEPTH);
    localparam logic [WW-1:0] WaitMax = WW'(MAX_WAIT);
    localparam logic [WW-1:0] WaitSet = WW'(MAX_WAIT - 1);

    logic [4:0]    r_mem_rd   [DEPTH];
    logic [31:0]   r_mem_data [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [WW-1:0] r_wait;
    logic          r_pipe_hold;
    logic [31:0]   r_busy;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_grant_pipe;
    logic [CW-1:0] w_count_next;
    logic [4:0]    w_head_rd;
    logic [31:0]   w_head_data;
    logic [4:0]    w_sel_rd;
    logic [31:0]   w_sel_data;
    logic [31:0]   w_busy_set;
    logic [31:0]   w_busy_clr;
    logic [31:0]   w_busy_next;

    assign w_full       = (r_count == FullCnt);
    assign w_empty      = (r_count == '0);
    assign lu_ready     = !rst && !w_full;
    assign w_push       = lu_valid && lu_ready;
    assign w_grant_pipe = !rst && !r_pipe_hold && pipe_wb_en;
    assign w_pop        = !rst && !w_grant_pipe && !w_empty;
    assign w_head_rd    = r_mem_rd[r_rd_ptr];
    assign w_head_data  = r_mem_data[r_rd_ptr];
    assign pipe_hold    = r_pipe_hold;

    always_comb begin
        w_sel_rd   = '0;
        w_sel_data = '0;
        if (w_grant_pipe) begin
            w_sel_rd   = pipe_wb_rd;
            w_sel_data = pipe_wb_data;
        end else if (w_pop) begin
            w_sel_rd   = w_head_rd;
            w_sel_data = w_head_data;
        end
    end

    // A granted x0 write is consumed but never reaches the register file.
    assign wb_en      = (w_grant_pipe || w_pop) && (w_sel_rd != 5'd0);
    assign W_rd_index = w_sel_rd;
    assign wb_data    = w_sel_data;

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - CW'(1);
        end
    end

    // Set beats clear on the same index so a re-issued op stays tracked.
    always_comb begin
        w_busy_set = '0;
        w_busy_clr = '0;
        if (lu_issue && (lu_issue_rd != 5'd0)) begin
            w_busy_set[lu_issue_rd] = 1'b1;
        end
        if (w_pop) begin
            w_busy_clr[w_head_rd] = 1'b1;
        end
        w_busy_next    = (r_busy & ~w_busy_clr) | w_busy_set;
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_rd[r_wr_ptr]   <= lu_rd;
            r_mem_data[r_wr_ptr] <= lu_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_wait      <= '0;
            r_pipe_hold <= 1'b0;
            r_busy      <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_next;
            r_busy  <= w_busy_next;

            if (w_empty || w_pop) begin
                r_wait <= '0;
            end else if (r_wait != WaitMax) begin
                r_wait <= r_wait + WW'(1);
            end

            if (w_pop) begin
                r_pipe_hold <= 1'b0;
            end else if ((!w_empty && (r_wait == WaitSet)) || (w_count_next == FullCnt)) begin
                r_pipe_hold <= 1'b1;
            end
        end
    end

`ifdef RF_WB_FORWARD_EN
    logic w_fifo_wr;
    logic w_mask_rs1;
    logic w_mask_rs2;

    assign w_fifo_wr    = wb_en && !w_grant_pipe;
    assign w_mask_rs1   = w_fifo_wr && (W_rd_index == id_rs1);
    assign w_mask_rs2   = w_fifo_wr && (W_rd_index == id_rs2);
    assign hazard_stall = !rst && ((r_busy[id_rs1] && !w_mask_rs1) ||
                                   (r_busy[id_rs2] && !w_mask_rs2) || r_busy[id_rd]);
    assign fwd_rs1_data = (wb_en && (W_rd_index == id_rs1)) ? wb_data : rf_rs1_data;
    assign fwd_rs2_data = (wb_en && (W_rd_index == id_rs2)) ? wb_data : rf_rs2_data;
`else
    assign hazard_stall = !rst && (r_busy[id_rs1] || r_busy[id_rs2] || r_busy[id_rd]);
`endif

    a_no_pipe_wr_during_hold: assert property (
        @(posedge clk) disable iff (rst) !(r_pipe_hold && pipe_wb_en));

endmodule

// File: tb/tb_rf_wb_sched.sv
// Directed bench for rf_wb_sched: long-latency results go into a scoreboard queue when driven
// and are popped and compared when the FIFO is expected to win the write port.
module tb_rf_wb_sched;
    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_wb_en;
    logic [4:0]  pipe_wb_rd;
    logic [31:0] pipe_wb_data;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic        lu_issue;
    logic [4:0]  lu_issue_rd;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic        hazard_stall;
    logic        pipe_hold;
    logic        wb_en;
    logic [4:0]  W_rd_index;
    logic [31:0] wb_data;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [36:0] lu_q[$];

    always #5 clk = ~clk;

    rf_wb_sched #(
        .DEPTH   (4),
        .MAX_WAIT(8)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .pipe_wb_en  (pipe_wb_en),
        .pipe_wb_rd  (pipe_wb_rd),
        .pipe_wb_data(pipe_wb_data),
        .lu_valid    (lu_valid),
        .lu_rd       (lu_rd),
        .lu_data     (lu_data),
        .lu_ready    (lu_ready),
        .lu_issue    (lu_issue),
        .lu_issue_rd (lu_issue_rd),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rd       (id_rd),
        .hazard_stall(hazard_stall),
        .pipe_hold   (pipe_hold),
        .wb_en       (wb_en),
        .W_rd_index  (W_rd_index),
        .wb_data     (wb_data)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic lu_drive(input logic [4:0] rd, input logic [31:0] data);
        lu_valid = 1'b1;
        lu_rd    = rd;
        lu_data  = data;
        lu_q.push_back({rd, data});
    endtask

    // The FIFO is expected to own the write port this cycle.
    task automatic chk_lu_write(input string tag);
        logic [36:0] e;
        n_checks++;
        assert (lu_q.size() != 0) else begin
            n_errors++;
            $error("FAIL %s observed=no_entry expected=queued_result", tag);
        end
        if (lu_q.size() != 0) begin
            e = lu_q.pop_front();
            chk({tag, "_en"}, {31'd0, wb_en}, {31'd0, (e[36:32] != 5'd0)});
            chk({tag, "_rd"}, {27'd0, W_rd_index}, {27'd0, e[36:32]});
            chk({tag, "_data"}, wb_data, e[31:0]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        pipe_wb_en   = 1'b0;
        pipe_wb_rd   = '0;
        pipe_wb_data = '0;
        lu_valid     = 1'b0;
        lu_rd        = '0;
        lu_data      = '0;
        lu_issue     = 1'b0;
        lu_issue_rd  = '0;
        id_rs1       = '0;
        id_rs2       = '0;
        id_rd        = '0;

        // Reset: outputs gated even with a pipeline request present.
        cyc();
        pipe_wb_en   = 1'b1;
        pipe_wb_rd   = 5'd5;
        pipe_wb_data = 32'h1234;
        #1;
        chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
        chk("rst_rd", {27'd0, W_rd_index}, 32'd0);
        chk("rst_data", wb_data, 32'd0);
        chk("rst_lu_ready", {31'd0, lu_ready}, 32'd0);
        chk("rst_stall", {31'd0, hazard_stall}, 32'd0);
        chk("rst_hold", {31'd0, pipe_hold}, 32'd0);

        // Pipeline pass-through.
        cyc();
        rst = 1'b0;
        #1;
        chk("pipe_wb_en", {31'd0, wb_en}, 32'd1);
        chk("pipe_rd", {27'd0, W_rd_index}, 32'd5);
        chk("pipe_data", wb_data, 32'h1234);
        chk("pipe_lu_ready", {31'd0, lu_ready}, 32'd1);
        pipe_wb_rd = 5'd0;
        #1;
        chk("pipe_x0_en", {31'd0, wb_en}, 32'd0);
        chk("pipe_x0_data", wb_data, 32'h1234);

        // Collision: starved FIFO entry forces pipe_hold after 8 cycles.
        cyc();
        pipe_wb_rd   = 5'd3;
        pipe_wb_data = 32'h3333;
        lu_issue     = 1'b1;
        lu_issue_rd  = 5'd7;
        cyc();
        lu_issue = 1'b0;
        id_rs1   = 5'd7;
        lu_drive(5'd7, 32'hAAAA);
        #1;
        chk("col_lu_ready", {31'd0, lu_ready}, 32'd1);
        chk("col_stall", {31'd0, hazard_stall}, 32'd1);
        chk("col_pipe_rd", {27'd0, W_rd_index}, 32'd3);
        cyc();
        lu_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("col_starve_rd", {27'd0, W_rd_index}, 32'd3);
            chk("col_starve_hold", {31'd0, pipe_hold}, 32'd0);
            cyc();
        end
        pipe_wb_en = 1'b0;
        #1;
        chk("col_hold", {31'd0, pipe_hold}, 32'd1);
        chk_lu_write("col_drain");
        chk("col_stall_during_pop", {31'd0, hazard_stall}, 32'd1);
        cyc();
        #1;
        chk("col_hold_drop", {31'd0, pipe_hold}, 32'd0);
        chk("col_stall_clear", {31'd0, hazard_stall}, 32'd0);
        chk("col_idle", {31'd0, wb_en}, 32'd0);
        id_rs1 = 5'd0;

        // FIFO full while the pipeline is busy; drain in push order.
        cyc();
        pipe_wb_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            lu_drive(5'(10 + i), 32'hB0 + 32'(i));
            #1;
            chk("full_lu_ready", {31'd0, lu_ready}, 32'd1);
            chk("full_pipe_rd", {27'd0, W_rd_index}, 32'd3);
            cyc();
        end
        lu_valid   = 1'b0;
        pipe_wb_en = 1'b0;
        #1;
        chk("full_lu_ready_low", {31'd0, lu_ready}, 32'd0);
        chk("full_hold", {31'd0, pipe_hold}, 32'd1);
        chk_lu_write("full_drain");
        cyc();
        lu_drive(5'd14, 32'hB4);
        #1;
        chk_lu_write("full_drain");
        chk("full_hold_drop", {31'd0, pipe_hold}, 32'd0);
        chk("full_lu_ready_back", {31'd0, lu_ready}, 32'd1);
        cyc();
        lu_valid = 1'b0;
        repeat (3) begin
            #1;
            chk_lu_write("full_drain");
            cyc();
        end
        #1;
        chk("full_idle", {31'd0, wb_en}, 32'd0);

        // Scoreboard: RAW/WAW stall, clear on pop, set beats clear.
        lu_issue    = 1'b1;
        lu_issue_rd = 5'd9;
        id_rs1      = 5'd9;
        #1;
        chk("sb_pre_stall", {31'd0, hazard_stall}, 32'd0);
        cyc();
        lu_issue = 1'b0;
        #1;
        chk("sb_rs1", {31'd0, hazard_stall}, 32'd1);
        id_rs1 = 5'd8;
        id_rs2 = 5'd9;
        #1;
        chk("sb_rs2", {31'd0, hazard_stall}, 32'd1);
        id_rs2 = 5'd0;
        id_rd  = 5'd9;
        #1;
        chk("sb_rd", {31'd0, hazard_stall}, 32'd1);
        id_rd = 5'd0;
        #1;
        chk("sb_other", {31'd0, hazard_stall}, 32'd0);
        id_rs1 = 5'd9;
        lu_drive(5'd9, 32'h99);
        cyc();
        lu_valid = 1'b0;
        #1;
        chk_lu_write("sb_pop");
        chk("sb_stall_at_pop", {31'd0, hazard_stall}, 32'd1);
        cyc();
        #1;
        chk("sb_cleared", {31'd0, hazard_stall}, 32'd0);
        lu_drive(5'd9, 32'h199);
        cyc();
        lu_valid    = 1'b0;
        lu_issue    = 1'b1;
        lu_issue_rd = 5'd9;
        #1;
        chk_lu_write("sb_pop2");
        cyc();
        lu_issue = 1'b0;
        #1;
        chk("sb_set_wins", {31'd0, hazard_stall}, 32'd1);
        lu_drive(5'd9, 32'h299);
        cyc();
        lu_valid = 1'b0;
        #1;
        chk_lu_write("sb_pop3");
        cyc();
        #1;
        chk("sb_final_clear", {31'd0, hazard_stall}, 32'd0);
        id_rs1 = 5'd0;

        // x0: consumed without a write; issue to x0 never stalls.
        lu_drive(5'd0, 32'h55);
        cyc();
        lu_valid = 1'b0;
        #1;
        chk_lu_write("x0_pop");
        lu_issue    = 1'b1;
        lu_issue_rd = 5'd0;
        cyc();
        lu_issue = 1'b0;
        #1;
        chk("x0_stall", {31'd0, hazard_stall}, 32'd0);
        chk("x0_consumed", wb_data, 32'd0);

        // Reset mid-operation discards pending results and busy bits.
        lu_issue     = 1'b1;
        lu_issue_rd  = 5'd4;
        pipe_wb_en   = 1'b1;
        pipe_wb_rd   = 5'd3;
        pipe_wb_data = 32'h3333;
        cyc();
        lu_issue = 1'b0;
        lu_valid = 1'b1;
        lu_rd    = 5'd4;
        lu_data  = 32'h44;
        cyc();
        lu_rd   = 5'd6;
        lu_data = 32'h66;
        cyc();
        lu_valid = 1'b0;
        id_rs1   = 5'd4;
        #1;
        chk("rm_stall_pre", {31'd0, hazard_stall}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rm_wb_en", {31'd0, wb_en}, 32'd0);
        chk("rm_rd", {27'd0, W_rd_index}, 32'd0);
        chk("rm_stall", {31'd0, hazard_stall}, 32'd0);
        chk("rm_lu_ready", {31'd0, lu_ready}, 32'd0);
        cyc();
        rst        = 1'b0;
        pipe_wb_en = 1'b0;
        repeat (4) begin
            #1;
            chk("rm_no_write", {31'd0, wb_en}, 32'd0);
            chk("rm_no_data", wb_data, 32'd0);
            chk("rm_stall_post", {31'd0, hazard_stall}, 32'd0);
            cyc();
        end
        #1;
        chk("rm_hold", {31'd0, pipe_hold}, 32'd0);
        chk("rm_lu_ready_back", {31'd0, lu_ready}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
